pea_scheduler: RTL

Sequencer for the 16-PE array.
- Walks centers × output-channel groups × input-channel chunks, issuing one read request per beat to the input/weight buffer.
- Delays each beat's control fields by the buffer read latency so they line up with the buffer's data on the Buffer_to_PEA control fields: `in_valid`, `out_ch`, `in_ch_end` and `new_center_in`.
- Sits between the layer-level controller (start/config/done) and the buffer/PE array.

---
 rtl/pea_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pea_scheduler.sv
// Beat sequencer for the 16-PE array: walks centers x output groups x input chunks,
// issues buffer reads and delays each beat's control fields by the buffer read latency.
module pea_scheduler #(
    parameter int PE_NUM = 16,
    parameter int PE_OPS = 4,
    parameter int CH_W   = 32,
    parameter int CTR_W  = 16,
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [CTR_W-1:0]         cfg_num_center_i,
    input  logic [8:0]               cfg_out_ch_i,
    input  logic [8:0]               cfg_in_ch_i,
    output logic                     rd_req_valid_o,
    input  logic                     rd_req_ready_i,
    output logic [6:0]               rd_ic_idx_o,
    output logic [3:0]               rd_og_idx_o,
    output logic [CTR_W-1:0]         rd_ctr_idx_o,
    output logic                     pea_in_valid_o,
    output logic [PE_NUM*CH_W-1:0]   pea_out_ch_o,
    output logic                     pea_in_ch_end_o,
    output logic                     pea_new_center_in_o,
    output logic [PE_NUM-1:0]        pea_pe_mask_o,
    output logic [PE_OPS-1:0]        pea_op_mask_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       icEnd;
        logic       newCenter;
        logic [3:0] og;
        logic [6:0] ic;
    } beat_t;

    state_t           state_q;
    logic             rdReqValid_q;
    logic             busy_q;
    logic             done_q;
    logic [6:0]       icIdx_q;
    logic [3:0]       ogIdx_q;
    logic [CTR_W-1:0] ctrIdx_q;
    logic [6:0]       icIdx_d;
    logic [3:0]       ogIdx_d;
    logic [CTR_W-1:0] ctrIdx_d;
    logic [6:0]       nicM1_q;
    logic [3:0]       nogM1_q;
    logic [CTR_W-1:0] ctrM1_q;
    logic [8:0]       outCh_q;
    logic [8:0]       inCh_q;

    logic             fire;
    logic             lastBeat;
    logic             cfgZero;
    logic [9:0]       nicFull;
    logic [9:0]       nogFull;
    beat_t            fireBeat_d;
    beat_t            pipe_q [RD_LAT];
    beat_t            outStage;
    logic             earlyStagesBusy;

    function automatic logic [9:0] laneChannel(input logic [3:0] og, input int p);
        return 10'(og) * 10'(PE_NUM) + 10'(p);
    endfunction

    function automatic logic [9:0] opChannel(input logic [6:0] ic, input int k);
        return 10'(ic) * 10'(PE_OPS) + 10'(k);
    endfunction

    assign fire    = rdReqValid_q & rd_req_ready_i;
    assign cfgZero = (cfg_num_center_i == '0) || (cfg_out_ch_i == '0) || (cfg_in_ch_i == '0);
    assign nicFull = ({1'b0, cfg_in_ch_i} + 10'(PE_OPS - 1)) / 10'(PE_OPS);
    assign nogFull = ({1'b0, cfg_out_ch_i} + 10'(PE_NUM - 1)) / 10'(PE_NUM);

    // Chunk index is innermost; the center counter only wraps on the final beat.
    always_comb begin
        icIdx_d  = icIdx_q;
        ogIdx_d  = ogIdx_q;
        ctrIdx_d = ctrIdx_q;
        lastBeat = 1'b0;
        if (icIdx_q != nicM1_q) begin
            icIdx_d = icIdx_q + 7'd1;
        end else begin
            icIdx_d = '0;
            if (ogIdx_q != nogM1_q) begin
                ogIdx_d = ogIdx_q + 4'd1;
            end else begin
                ogIdx_d = '0;
                if (ctrIdx_q != ctrM1_q) begin
                    ctrIdx_d = ctrIdx_q + CTR_W'(1);
                end else begin
                    ctrIdx_d = '0;
                    lastBeat = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fireBeat_d = '0;
        if (fire) begin
            fireBeat_d.valid     = 1'b1;
            fireBeat_d.icEnd     = (icIdx_q == nicM1_q);
            fireBeat_d.newCenter = (ogIdx_q == 4'd0) && (icIdx_q == 7'd0);
            fireBeat_d.og        = ogIdx_q;
            fireBeat_d.ic        = icIdx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rdReqValid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            icIdx_q      <= '0;
            ogIdx_q      <= '0;
            ctrIdx_q     <= '0;
            nicM1_q      <= '0;
            nogM1_q      <= '0;
            ctrM1_q      <= '0;
            outCh_q      <= '0;
            inCh_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q   <= 1'b1;
                        icIdx_q  <= '0;
                        ogIdx_q  <= '0;
                        ctrIdx_q <= '0;
                        nicM1_q  <= 7'(nicFull - 10'd1);
                        nogM1_q  <= 4'(nogFull - 10'd1);
                        ctrM1_q  <= cfg_num_center_i - CTR_W'(1);
                        outCh_q  <= cfg_out_ch_i;
                        inCh_q   <= cfg_in_ch_i;
                        if (cfgZero) begin
                            state_q <= DONE;
                        end else begin
                            state_q      <= RUN;
                            rdReqValid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        icIdx_q  <= icIdx_d;
                        ogIdx_q  <= ogIdx_d;
                        ctrIdx_q <= ctrIdx_d;
                        if (lastBeat) begin
                            rdReqValid_q <= 1'b0;
                            state_q      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!earlyStagesBusy) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // A zero-size job arrives here with done low and spends one extra cycle raising it.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= fireBeat_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // The last stage is on the outputs this cycle, so it empties at the next edge on its own.
    always_comb begin
        earlyStagesBusy = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            earlyStagesBusy = earlyStagesBusy | pipe_q[i].valid;
        end
    end

    assign outStage = pipe_q[RD_LAT-1];

    always_comb begin
        pea_out_ch_o  = '0;
        pea_pe_mask_o = '0;
        pea_op_mask_o = '0;
        if (outStage.valid) begin
            for (int p = 0; p < PE_NUM; p++) begin
                pea_out_ch_o[p*CH_W +: CH_W] = CH_W'(laneChannel(outStage.og, p));
                pea_pe_mask_o[p]             = laneChannel(outStage.og, p) < {1'b0, outCh_q};
            end
            for (int k = 0; k < PE_OPS; k++) begin
                pea_op_mask_o[k] = opChannel(outStage.ic, k) < {1'b0, inCh_q};
            end
        end
    end

    assign pea_in_valid_o      = outStage.valid;
    assign pea_in_ch_end_o     = outStage.valid & outStage.icEnd;
    assign pea_new_center_in_o = outStage.valid & outStage.newCenter;
    assign rd_req_valid_o      = rdReqValid_q;
    assign rd_ic_idx_o         = icIdx_q;
    assign rd_og_idx_o         = ogIdx_q;
    assign rd_ctr_idx_o        = ctrIdx_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;

endmodule
